axi_lite_slave: RTL and testbench

AXI4-Lite responder: terminates the five AXI-Lite channels driven by the team's AXI-Lite master and backs them with a byte-writable register file of `NUM_REGS` 32-bit registers. Read and write paths are independent. Out-of-range accesses complete with SLVERR, and register contents are exported for system use and checking.

---
 rtl/axi_lite_pkg.sv | 23 ++
 rtl/axi_lite_regfile.sv | 38 +++
 rtl/axi_lite_slave.sv | 140 ++++++++++++++
 tb/tb_axi_lite_slave.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, read FSM encoding and
// the register-range decode used by the master and slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Word address (ADDR[31:2]) selects a register only below num_regs.
  function automatic logic addr_in_range(input logic [29:0] word_addr,
                                         input int unsigned num_regs);
    return {2'b00, word_addr} < num_regs;
  endfunction

  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// NUM_REGS x 32-bit register file: byte-enabled write port, combinational
// read port and a flat export of every register.
module axi_lite_regfile #(
  parameter  int NUM_REGS = 8,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic [IDX_W-1:0]         ridx,
  output logic [31:0]              rdata,
  output logic [32*NUM_REGS-1:0]   regs_flat
);

  logic [31:0] mem [NUM_REGS];

  // NOTE: the storage is reset because software and the system export rely
  // on every register reading zero after reset; this keeps it in flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
    assign regs_flat[32*i +: 32] = mem[i];
  end

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite responder over a byte-writable register file; the write and
// read channels run independently of each other.
module axi_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            AWADDR,
  input  logic [2:0]             AWPROT,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [31:0]            WDATA,
  input  logic [3:0]             WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [31:0]            ARADDR,
  input  logic [2:0]             ARPROT,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [31:0]            RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [32*NUM_REGS-1:0] regs_flat
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic        aw_held, w_held, aw_held_n, w_held_n;
  logic        awready_q, wready_q, arready_q;
  logic        bvalid_q, bvalid_n;
  logic [1:0]  bresp_q, bresp_n;
  logic [29:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        commit, wr_in_range, rd_in_range;
  rd_state_e   state_q, state_n;
  logic [31:0] rdata_q, rdata_n, rf_rdata;
  logic [1:0]  rresp_q, rresp_n;
  logic        unused_ok;

  assign unused_ok   = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
  assign commit      = aw_held & w_held;
  assign wr_in_range = addr_in_range(awaddr_q, NUM_REGS);
  assign rd_in_range = addr_in_range(ARADDR[31:2], NUM_REGS);

  axi_lite_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (commit & wr_in_range),
    .widx      (awaddr_q[IDX_W-1:0]),
    .wdata     (wdata_q),
    .wstrb     (wstrb_q),
    .ridx      (ARADDR[IDX_W+1:2]),
    .rdata     (rf_rdata),
    .regs_flat (regs_flat)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    aw_held_n = aw_held | (AWVALID & awready_q);
    w_held_n  = w_held  | (WVALID & wready_q);
    bvalid_n  = bvalid_q & ~BREADY;
    bresp_n   = bresp_q;
    if (commit) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      bvalid_n  = 1'b1;
      bresp_n   = resp_for(wr_in_range);
    end
  end

  always_comb begin
    state_n = state_q;
    rdata_n = rdata_q;
    rresp_n = rresp_q;
    unique case (state_q)
      R_IDLE: if (ARVALID & arready_q) begin
        // Register read is combinational, so a same-edge write is not seen.
        rdata_n = rd_in_range ? rf_rdata : '0;
        rresp_n = resp_for(rd_in_range);
        state_n = R_DATA;
      end
      R_DATA: if (RREADY) state_n = R_IDLE;
      default: state_n = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      state_q   <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      awready_q <= ~aw_held_n & ~bvalid_n;
      wready_q  <= ~w_held_n & ~bvalid_n;
      arready_q <= (state_n == R_IDLE);
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
      state_q   <= state_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
      if (AWVALID & awready_q) awaddr_q <= AWADDR[31:2];
      if (WVALID & wready_q) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = (state_q == R_DATA);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed plus randomized bench for axi_lite_slave (NUM_REGS = 8) against
// an array-based model of the register file and response rules.
module tb_axi_lite_slave;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    AWADDR, WDATA, ARADDR;
  logic [2:0]     AWPROT, ARPROT;
  logic           AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [3:0]     WSTRB;
  logic           AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]     BRESP, RRESP;
  logic [31:0]    RDATA;
  logic [32*N-1:0] regs_flat;

  int total = 0;
  int bad   = 0;
  logic [31:0] m [N];

  axi_lite_slave #(.NUM_REGS(N)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f = '0;
    for (int i = 0; i < N; i++) f[32*i +: 32] = m[i];
    return f;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] addr);
    return (addr / 4 < N) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] addr);
    return (addr / 4 < N) ? m[addr / 4] : 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    logic [31:0] mask = '0;
    int idx;
    if (addr / 4 >= N) return;
    idx = int'(addr / 4);
    for (int k = 0; k < 4; k++) if (strb[k]) mask = mask | (32'hFF << (8 * k));
    m[idx] = (m[idx] & ~mask) | (data & mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_go, w_go;
    int cyc = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    while ((AWVALID || WVALID) && cyc < 20) begin
      aw_go = AWREADY; w_go = WREADY;
      tick();
      if (aw_go) AWVALID = 1'b0;
      if (w_go)  WVALID  = 1'b0;
      cyc++;
    end
    check("wr_accept_timeout", {AWVALID, WVALID}, 0);
    AWVALID = 1'b0; WVALID = 1'b0;
    cyc = 0;
    while (!BVALID && cyc < 20) begin tick(); cyc++; end
    check("wr_bvalid", BVALID, 1);
    check("wr_bresp", BRESP, exp_resp(addr));
    model_write(addr, data, strb);
    check("wr_regs", regs_flat, model_flat());
    tick();
    BREADY = 1'b0;
    check("wr_bvalid_drop", BVALID, 0);
  endtask

  task automatic do_read(input logic [31:0] addr);
    logic go;
    int cyc = 0;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    while (ARVALID && cyc < 20) begin
      go = ARREADY;
      tick();
      if (go) ARVALID = 1'b0;
      cyc++;
    end
    check("rd_accept_timeout", ARVALID, 0);
    ARVALID = 1'b0;
    check("rd_rvalid", RVALID, 1);
    check("rd_rdata", RDATA, exp_read(addr));
    check("rd_rresp", RRESP, exp_resp(addr));
    tick();
    RREADY = 1'b0;
    check("rd_rvalid_drop", RVALID, 0);
    check("rd_arready_back", ARREADY, 1);
  endtask

  initial begin
    logic [31:0] d, a, old;
    rst = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < N; i++) m[i] = '0;

    // Reset state and ready release timing
    repeat (2) tick();
    check("rst_readies", {AWREADY, WREADY, ARREADY}, 0);
    check("rst_valids", {BVALID, RVALID}, 0);
    check("rst_data", {RDATA, BRESP, RRESP}, 0);
    check("rst_regs", regs_flat, 0);
    rst = 1'b1;
    #1;
    check("rel_readies_low", {AWREADY, WREADY, ARREADY}, 0);
    tick();
    check("rel_readies_high", {AWREADY, WREADY, ARREADY}, 3'b111);

    // AW and W on the same edge, with exact latency
    AWADDR = 32'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check("same_edge_held", {AWREADY, WREADY, BVALID}, 0);
    tick();
    check("same_edge_bvalid", BVALID, 1);
    check("same_edge_bresp", BRESP, 2'b00);
    check("same_edge_reg1", regs_flat[63:32], 32'hDEADBEEF);
    model_write(32'h04, 32'hDEADBEEF, 4'hF);
    tick();
    check("same_edge_bdrop", {BVALID, AWREADY, WREADY}, 3'b011);
    BREADY = 1'b0;
    do_read(32'h04);

    // W accepted three cycles before AW, partial strobe
    do_write(32'h08, 32'hFFFFFFFF, 4'hF);
    WDATA = 32'h11223344; WSTRB = 4'b0111; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("w_first_wready_low", WREADY, 0);
      check("w_first_no_bvalid", BVALID, 0);
      tick();
    end
    AWADDR = 32'h08; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("w_first_wait", {BVALID, WREADY}, 0);
    tick();
    check("w_first_bvalid", {BVALID, WREADY, BRESP}, 4'b1000);
    check("w_first_reg2", regs_flat[95:64], 32'hFF223344);
    model_write(32'h08, 32'h11223344, 4'b0111);
    tick();
    check("w_first_wready_back", {BVALID, WREADY}, 2'b01);
    BREADY = 1'b0;

    // Out of range write and read
    do_write(32'h20, 32'h12345678, 4'hF);
    check("oor_regs_unchanged", regs_flat, model_flat());
    do_read(32'h20);

    // Backpressure on both response channels
    d = $urandom;
    AWADDR = 32'h10; WDATA = d; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    ARADDR = 32'h04; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    old = m[1];
    check("bp_rvalid", RVALID, 1);
    tick();
    model_write(32'h10, d, 4'hF);
    check("bp_regs", regs_flat, model_flat());
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", {BVALID, BRESP}, 3'b100);
      check("bp_rdata", {RVALID, RDATA, RRESP}, {1'b1, old, 2'b00});
      check("bp_readies", {AWREADY, WREADY, ARREADY}, 0);
      tick();
    end
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    check("bp_release", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
    BREADY = 1'b0; RREADY = 1'b0;

    // Read captured on the same edge as a write commit to that register
    do_write(32'h0C, 32'hA, 4'hF);
    AWADDR = 32'h0C; WDATA = 32'hB; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check("col_arready", ARREADY, 1);
    ARADDR = 32'h0C; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    check("col_both_valid", {BVALID, RVALID}, 2'b11);
    check("col_rdata_old", RDATA, 32'hA);
    check("col_reg3_new", regs_flat[127:96], 32'hB);
    model_write(32'h0C, 32'hB, 4'hF);
    RREADY = 1'b1;
    tick();
    check("col_done", {BVALID, RVALID}, 0);
    BREADY = 1'b0; RREADY = 1'b0;

    // Randomized traffic, including ignored byte offsets and high addresses
    for (int it = 0; it < 24; it++) begin
      a = 32'($urandom_range(0, 9) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h1000_0000;
      do_write(a, $urandom, 4'($urandom_range(0, 15)));
      do_read(32'($urandom_range(0, 10) * 4));
    end

    // Async reset while AW is held and W is still pending
    AWADDR = 32'h14; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("mid_aw_held", {AWREADY, WREADY}, 2'b01);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_immediate", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 0);
    check("mid_rst_regs", regs_flat, 0);
    for (int i = 0; i < N; i++) m[i] = '0;
    tick();
    check("mid_rst_hold", {AWREADY, WREADY, ARREADY}, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rel_low", {AWREADY, WREADY, ARREADY}, 0);
    tick();
    check("mid_rel_high", {AWREADY, WREADY, ARREADY}, 3'b111);
    WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    repeat (2) tick();
    WVALID = 1'b0;
    check("mid_no_stale_commit", {BVALID, regs_flat}, 0);
    BREADY = 1'b0;
    for (int i = 0; i <= N; i++) do_read(32'(i * 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
